// File: rtl/xgmii_pkg.sv
// Shared constants, types and character-mapping helpers for the 64b/66b
// receive decoder.
package xgmii_pkg;

   // Sync headers
   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CTRL = 2'b10;

   // Control block types (byte 0 of a control block)
   localparam logic [7:0] BT_C8    = 8'h1E;
   localparam logic [7:0] BT_C4_O4 = 8'h2D;
   localparam logic [7:0] BT_C4_S4 = 8'h33;
   localparam logic [7:0] BT_O0_S4 = 8'h66;
   localparam logic [7:0] BT_O0_O4 = 8'h55;
   localparam logic [7:0] BT_S0    = 8'h78;
   localparam logic [7:0] BT_O0_C4 = 8'h4B;
   localparam logic [7:0] BT_T0    = 8'h87;
   localparam logic [7:0] BT_T1    = 8'h99;
   localparam logic [7:0] BT_T2    = 8'hAA;
   localparam logic [7:0] BT_T3    = 8'hB4;
   localparam logic [7:0] BT_T4    = 8'hCC;
   localparam logic [7:0] BT_T5    = 8'hD2;
   localparam logic [7:0] BT_T6    = 8'hE1;
   localparam logic [7:0] BT_T7    = 8'hFF;

   // XGMII characters
   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERROR = 8'hFE;
   localparam logic [7:0] XGMII_SEQ   = 8'h9C;
   localparam logic [7:0] XGMII_SIG   = 8'h5C;

   // 7-bit control codes and 4-bit O-codes
   localparam logic [6:0] CODE_IDLE  = 7'h00;
   localparam logic [6:0] CODE_ERROR = 7'h1E;
   localparam logic [3:0] O_SEQ      = 4'h0;

   // Whole-beat words
   localparam logic [31:0] IDLE_WORD  = 32'h0707_0707;
   localparam logic [31:0] ERROR_WORD = 32'hFEFE_FEFE;
   localparam logic [31:0] LF_WORD    = 32'h0100_009C;
   localparam logic [3:0]  LF_CTRL    = 4'b0001;
   localparam logic [3:0]  ALL_CTRL   = 4'hF;

   typedef enum logic {
      WAIT_A,
      WAIT_B
   } rx_state_e;

   // Returns {err, character} for a 7-bit control code.
   function automatic logic [8:0] decode_ctrl(input logic [6:0] code);
      case (code)
         CODE_IDLE:  return {1'b0, XGMII_IDLE};
         CODE_ERROR: return {1'b0, XGMII_ERROR};
         default:    return {1'b1, XGMII_ERROR};
      endcase
   endfunction

   function automatic logic [7:0] decode_o(input logic [3:0] ocode);
      return (ocode == O_SEQ) ? XGMII_SEQ : XGMII_SIG;
   endfunction

endpackage

// File: rtl/xgmii_block_decode.sv
// Combinational 64b/66b block decoder: header + 64-bit block to eight XGMII
// lanes with per-lane control flags and a block-level error flag.
module xgmii_block_decode
   import xgmii_pkg::*;
(
   input  logic [1:0]  hdr_i,
   input  logic [63:0] block_i,
   output logic [63:0] rxd_o,
   output logic [7:0]  rxc_o,
   output logic        err_o
);

   logic [7:0][7:0] code_chr;
   logic [7:0]      code_err;
   logic [7:0][7:0] lane;
   logic [63:0]     blk_sh;
   logic [7:0]      o0_chr;
   logic [7:0]      o4_chr;
   logic            t_hit;
   logic [2:0]      t_pos;

   // Control code i always sits at bit 8+7i, whatever the block type.
   for (genvar i = 0; i < 8; i++) begin : g_code
      assign {code_err[i], code_chr[i]} = decode_ctrl(block_i[8+7*i +: 7]);
   end

   // Terminate blocks carry data lane j in block byte j+1.
   assign blk_sh = block_i >> 8;
   assign o0_chr = decode_o(block_i[35:32]);
   assign o4_chr = decode_o(block_i[39:36]);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      t_hit = 1'b1;
      t_pos = 3'd0;
      case (block_i[7:0])
         BT_T0:   t_pos = 3'd0;
         BT_T1:   t_pos = 3'd1;
         BT_T2:   t_pos = 3'd2;
         BT_T3:   t_pos = 3'd3;
         BT_T4:   t_pos = 3'd4;
         BT_T5:   t_pos = 3'd5;
         BT_T6:   t_pos = 3'd6;
         BT_T7:   t_pos = 3'd7;
         default: t_hit = 1'b0;
      endcase
   end

   always_comb begin
      lane  = {8{XGMII_ERROR}};
      rxc_o = 8'hFF;
      err_o = 1'b0;
      if (hdr_i == HDR_DATA) begin
         lane  = block_i;
         rxc_o = 8'h00;
      end else if (hdr_i != HDR_CTRL) begin
         err_o = 1'b1;
      end else if (t_hit) begin
         for (int j = 0; j < 8; j++) begin
            if (j < int'(t_pos))       lane[j] = blk_sh[8*j +: 8];
            else if (j == int'(t_pos)) lane[j] = XGMII_TERM;
            else                       lane[j] = code_chr[j];
         end
         rxc_o = 8'hFF << t_pos;
         err_o = |(code_err & (8'hFE << t_pos));
      end else begin
         case (block_i[7:0])
            BT_C8: begin
               lane  = code_chr;
               err_o = |code_err;
            end
            BT_C4_O4: begin
               lane[3:0] = code_chr[3:0];
               lane[4]   = o4_chr;
               lane[7:5] = block_i[63:40];
               rxc_o     = 8'h1F;
               err_o     = |code_err[3:0];
            end
            BT_C4_S4: begin
               lane[3:0] = code_chr[3:0];
               lane[4]   = XGMII_START;
               lane[7:5] = block_i[63:40];
               rxc_o     = 8'h1F;
               err_o     = |code_err[3:0];
            end
            BT_O0_S4: begin
               lane[0]   = o0_chr;
               lane[3:1] = block_i[31:8];
               lane[4]   = XGMII_START;
               lane[7:5] = block_i[63:40];
               rxc_o     = 8'h11;
            end
            BT_O0_O4: begin
               lane[0]   = o0_chr;
               lane[3:1] = block_i[31:8];
               lane[4]   = o4_chr;
               lane[7:5] = block_i[63:40];
               rxc_o     = 8'h11;
            end
            BT_S0: begin
               lane[0]   = XGMII_START;
               lane[7:1] = block_i[63:8];
               rxc_o     = 8'h01;
            end
            BT_O0_C4: begin
               lane[0]   = o0_chr;
               lane[3:1] = block_i[31:8];
               lane[7:4] = code_chr[7:4];
               rxc_o     = 8'hF1;
               err_o     = |code_err[7:4];
            end
            default: err_o = 1'b1;
         endcase
      end
   end

   assign rxd_o = lane;

endmodule

// File: rtl/xgmii_rx_decoder.sv
// 64b/66b receive decoder: reassembles two-beat blocks, decodes them and
// streams 32-bit XGMII rxd/rxc with alignment and block-lock handling.
module xgmii_rx_decoder
   import xgmii_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 4,
   parameter int HDR_WIDTH  = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic [HDR_WIDTH-1:0]  i_rx_hdr,
   input  logic                  i_rx_valid,
   input  logic                  i_rx_hdr_valid,
   input  logic                  i_block_lock,
   output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
   output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
   output logic                  o_xgmii_valid,
   output logic                  o_decoding_err
);

   rx_state_e               state_q;
   logic [DATA_WIDTH-1:0]   a_data_q;
   logic [HDR_WIDTH-1:0]    a_hdr_q;
   logic [DATA_WIDTH-1:0]   upper_d_q;
   logic [CTRL_WIDTH-1:0]   upper_c_q;
   logic [DATA_WIDTH-1:0]   rxd_q;
   logic [CTRL_WIDTH-1:0]   rxc_q;
   logic                    valid_q;
   logic                    err_q;

   logic [2*DATA_WIDTH-1:0] dec_rxd;
   logic [2*CTRL_WIDTH-1:0] dec_rxc;
   logic                    dec_err;

   // The block is decoded in the cycle its B beat arrives.
   xgmii_block_decode u_block_decode (
      .hdr_i   (a_hdr_q),
      .block_i ({i_rx_data, a_data_q}),
      .rxd_o   (dec_rxd),
      .rxc_o   (dec_rxc),
      .err_o   (dec_err)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= WAIT_A;
         a_data_q  <= '0;
         a_hdr_q   <= '0;
         upper_d_q <= IDLE_WORD;
         upper_c_q <= ALL_CTRL;
         rxd_q     <= IDLE_WORD;
         rxc_q     <= ALL_CTRL;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         valid_q <= i_rx_valid;
         err_q   <= 1'b0;
         if (!i_block_lock) begin
            state_q   <= WAIT_A;
            upper_d_q <= IDLE_WORD;
            upper_c_q <= ALL_CTRL;
            if (i_rx_valid) begin
               rxd_q <= LF_WORD;
               rxc_q <= LF_CTRL;
            end
         end else if (i_rx_valid) begin
            case (state_q)
               WAIT_A: begin
                  if (i_rx_hdr_valid) begin
                     a_data_q <= i_rx_data;
                     a_hdr_q  <= i_rx_hdr;
                     rxd_q    <= upper_d_q;
                     rxc_q    <= upper_c_q;
                     state_q  <= WAIT_B;
                  end else begin
                     rxd_q     <= ERROR_WORD;
                     rxc_q     <= ALL_CTRL;
                     err_q     <= 1'b1;
                     upper_d_q <= IDLE_WORD;
                     upper_c_q <= ALL_CTRL;
                  end
               end
               WAIT_B: begin
                  if (i_rx_hdr_valid) begin
                     // A second A beat restarts the block; the old A is lost.
                     a_data_q  <= i_rx_data;
                     a_hdr_q   <= i_rx_hdr;
                     rxd_q     <= ERROR_WORD;
                     rxc_q     <= ALL_CTRL;
                     err_q     <= 1'b1;
                     upper_d_q <= IDLE_WORD;
                     upper_c_q <= ALL_CTRL;
                  end else begin
                     rxd_q     <= dec_rxd[DATA_WIDTH-1:0];
                     rxc_q     <= dec_rxc[CTRL_WIDTH-1:0];
                     err_q     <= dec_err;
                     upper_d_q <= dec_rxd[2*DATA_WIDTH-1:DATA_WIDTH];
                     upper_c_q <= dec_rxc[2*CTRL_WIDTH-1:CTRL_WIDTH];
                     state_q   <= WAIT_A;
                  end
               end
               default: state_q <= WAIT_A;
            endcase
         end
      end
   end

   assign o_xgmii_rxd    = rxd_q;
   assign o_xgmii_rxc    = rxc_q;
   assign o_xgmii_valid  = valid_q;
   assign o_decoding_err = err_q;

endmodule

// File: tb/tb_xgmii_rx_decoder.sv
// Directed bench for xgmii_rx_decoder: hand-computed expected beats checked
// one cycle after each input beat.
module tb_xgmii_rx_decoder;

   logic        clk;
   logic        rst_n;
   logic [31:0] rx_data;
   logic [1:0]  rx_hdr;
   logic        rx_valid;
   logic        rx_hdr_valid;
   logic        block_lock;
   logic [31:0] xgmii_rxd;
   logic [3:0]  xgmii_rxc;
   logic        xgmii_valid;
   logic        decoding_err;

   int checks = 0;
   int errors = 0;

   xgmii_rx_decoder dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_rx_data      (rx_data),
      .i_rx_hdr       (rx_hdr),
      .i_rx_valid     (rx_valid),
      .i_rx_hdr_valid (rx_hdr_valid),
      .i_block_lock   (block_lock),
      .o_xgmii_rxd    (xgmii_rxd),
      .o_xgmii_rxc    (xgmii_rxc),
      .o_xgmii_valid  (xgmii_valid),
      .o_decoding_err (decoding_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one beat at the falling edge, then land just after the rising edge.
   task automatic beat(input logic [31:0] d, input logic [1:0] h, input logic v,
                       input logic hv, input logic lock);
      @(negedge clk);
      rx_data      = d;
      rx_hdr       = h;
      rx_valid     = v;
      rx_hdr_valid = hv;
      block_lock   = lock;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] exp_d, input logic [3:0] exp_c,
                        input logic exp_v, input logic exp_e);
      logic [37:0] obs;
      logic [37:0] exp;
      obs = {xgmii_rxd, xgmii_rxc, xgmii_valid, decoding_err};
      exp = {exp_d, exp_c, exp_v, exp_e};
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed rxd=%h rxc=%h valid=%b err=%b, expected rxd=%h rxc=%h valid=%b err=%b",
                tag, xgmii_rxd, xgmii_rxc, xgmii_valid, decoding_err,
                exp_d, exp_c, exp_v, exp_e);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      rx_data      = '0;
      rx_hdr       = 2'b00;
      rx_valid     = 1'b0;
      rx_hdr_valid = 1'b0;
      block_lock   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset", 32'h07070707, 4'hF, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle block
      beat(32'h0000001E, 2'b10, 1, 1, 1); check("idle_a", 32'h07070707, 4'hF, 1, 0);
      beat(32'h00000000, 2'b00, 1, 0, 1); check("idle_b", 32'h07070707, 4'hF, 1, 0);

      // Start block then data block
      beat(32'h03020178, 2'b10, 1, 1, 1); check("start_a", 32'h07070707, 4'hF, 1, 0);
      beat(32'h07060504, 2'b00, 1, 0, 1); check("start_b", 32'h030201FB, 4'h1, 1, 0);
      beat(32'h04030201, 2'b01, 1, 1, 1); check("data_a", 32'h07060504, 4'h0, 1, 0);
      beat(32'h08070605, 2'b00, 1, 0, 1); check("data_b", 32'h04030201, 4'h0, 1, 0);

      // Terminate in lane 0, lane 7 and lane 6
      beat(32'h00000087, 2'b10, 1, 1, 1); check("t0_a", 32'h08070605, 4'h0, 1, 0);
      beat(32'h00000000, 2'b00, 1, 0, 1); check("t0_b", 32'h070707FD, 4'hF, 1, 0);
      beat(32'h030201FF, 2'b10, 1, 1, 1); check("t7_a", 32'h07070707, 4'hF, 1, 0);
      beat(32'h07060504, 2'b00, 1, 0, 1); check("t7_b", 32'h04030201, 4'h0, 1, 0);
      beat(32'h030201E1, 2'b10, 1, 1, 1); check("t6_a", 32'hFD070605, 4'h8, 1, 0);
      beat(32'h00060504, 2'b00, 1, 0, 1); check("t6_b", 32'h04030201, 4'h0, 1, 0);

      // C8 block: code 0x1E is a plain /E/, code 0x01 is a decode error
      beat(32'h000F001E, 2'b10, 1, 1, 1); check("c8_a", 32'h07FD0605, 4'hC, 1, 0);
      beat(32'h00000000, 2'b00, 1, 0, 1); check("c8_b", 32'h0707FE07, 4'hF, 1, 0);
      beat(32'h0000011E, 2'b10, 1, 1, 1); check("badcode_a", 32'h07070707, 4'hF, 1, 0);
      beat(32'h00000000, 2'b00, 1, 0, 1); check("badcode_b", 32'h070707FE, 4'hF, 1, 1);

      // Ordered-set blocks: O0=0 -> 0x9C, O4=3 -> 0x5C
      beat(32'h0302014B, 2'b10, 1, 1, 1); check("o0c4_a", 32'h07070707, 4'hF, 1, 0);
      beat(32'h00000000, 2'b00, 1, 0, 1); check("o0c4_b", 32'h0302019C, 4'h1, 1, 0);
      beat(32'h0000002D, 2'b10, 1, 1, 1); check("c4o4_a", 32'h07070707, 4'hF, 1, 0);
      beat(32'h07060530, 2'b00, 1, 0, 1); check("c4o4_b", 32'h07070707, 4'hF, 1, 0);

      // Bad header and unknown block type
      beat(32'h12345678, 2'b11, 1, 1, 1); check("badhdr_a", 32'h0706055C, 4'h1, 1, 0);
      beat(32'h9ABCDEF0, 2'b00, 1, 0, 1); check("badhdr_b", 32'hFEFEFEFE, 4'hF, 1, 1);
      beat(32'h00000042, 2'b10, 1, 1, 1); check("badtype_a", 32'hFEFEFEFE, 4'hF, 1, 0);
      beat(32'h00000000, 2'b00, 1, 0, 1); check("badtype_b", 32'hFEFEFEFE, 4'hF, 1, 1);

      // Three-cycle pause between A and B
      beat(32'h0000001E, 2'b10, 1, 1, 1); check("pause_a", 32'hFEFEFEFE, 4'hF, 1, 0);
      beat(32'h00000000, 2'b00, 0, 0, 1); check("pause_gap0", 32'hFEFEFEFE, 4'hF, 0, 0);
      beat(32'hFFFFFFFF, 2'b11, 0, 1, 1); check("pause_gap1", 32'hFEFEFEFE, 4'hF, 0, 0);
      beat(32'h00000000, 2'b00, 0, 0, 1); check("pause_gap2", 32'hFEFEFEFE, 4'hF, 0, 0);
      beat(32'h00000000, 2'b00, 1, 0, 1); check("pause_b", 32'h07070707, 4'hF, 1, 0);

      // Two consecutive A beats, then normal decode of the second block
      beat(32'h03020178, 2'b10, 1, 1, 1); check("dblA_first", 32'h07070707, 4'hF, 1, 0);
      beat(32'h0B0A0978, 2'b10, 1, 1, 1); check("dblA_second", 32'hFEFEFEFE, 4'hF, 1, 1);
      beat(32'h0F0E0D0C, 2'b00, 1, 0, 1); check("dblA_b", 32'h0B0A09FB, 4'h1, 1, 0);

      // Stray B in WAIT_A flushes the held upper half to idle
      beat(32'hDEADBEEF, 2'b00, 1, 0, 1); check("misalign", 32'hFEFEFEFE, 4'hF, 1, 1);
      beat(32'h44332211, 2'b01, 1, 1, 1); check("misalign_a", 32'h07070707, 4'hF, 1, 0);
      beat(32'h88776655, 2'b00, 1, 0, 1); check("misalign_b", 32'h44332211, 4'h0, 1, 0);

      // Block lock lost mid-block, then relock
      beat(32'h03020178, 2'b10, 1, 1, 1); check("lock_a", 32'h88776655, 4'h0, 1, 0);
      beat(32'h07060504, 2'b00, 1, 0, 0); check("nolock_b", 32'h0100009C, 4'h1, 1, 0);
      beat(32'h0000001E, 2'b10, 1, 1, 0); check("nolock_a", 32'h0100009C, 4'h1, 1, 0);
      beat(32'h00000000, 2'b00, 0, 0, 0); check("nolock_pause", 32'h0100009C, 4'h1, 0, 0);
      beat(32'h0000001E, 2'b10, 1, 1, 1); check("relock_a", 32'h07070707, 4'hF, 1, 0);
      beat(32'h00000000, 2'b00, 1, 0, 1); check("relock_b", 32'h07070707, 4'hF, 1, 0);

      // Reset between A and B returns the FSM to WAIT_A
      beat(32'h03020178, 2'b10, 1, 1, 1); check("rstmid_a", 32'h07070707, 4'hF, 1, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstmid_reset", 32'h07070707, 4'hF, 0, 0);
      @(negedge clk);
      rx_valid = 1'b0;
      rst_n    = 1'b1;
      beat(32'h07060504, 2'b00, 1, 0, 1); check("rstmid_b", 32'hFEFEFEFE, 4'hF, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
